bin_to_bcd_digits: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3, one bit per clock).

---
 rtl/bin_to_bcd_digits.sv | 124 ++++++++++++
 tb/tb_bin_to_bcd_digits.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_digits.sv
// Sequential shift-add-3 binary-to-BCD converter feeding a 4-digit display driver.
// Optional macro ERROR_STICKY_EN: error holds until err_clr instead of clearing on each result.
module bin_to_bcd_digits #(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned MAX_VAL = 9999,
  parameter logic [3:0]  ERR_OVF = 4'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             err_clr,
  output logic             out_valid,
  output logic [3:0]       num0,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3,
  output logic [3:0]       error
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone, StOvf} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [15:0]       acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       digits_q, digits_d;
  logic [3:0]        error_q, error_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q;
  logic [15:0]       acc_corr;
  logic              transfer;

`ifndef ERROR_STICKY_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  assign transfer = in_valid && in_ready_q;

  // Add 3 to any nibble >= 5 so the following shift carries correctly into the next digit.
  always_comb begin
    acc_corr = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_corr[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    digits_d    = digits_q;
    error_d     = error_q;
    out_valid_d = 1'b0;
`ifdef ERROR_STICKY_EN
    if (err_clr) error_d = 4'd0;
`endif
    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          shreg_d = bin_in;
          acc_d   = 16'd0;
          cnt_d   = CntW'(WIDTH - 1);
          state_d = (32'(bin_in) > MAX_VAL) ? StOvf : StShift;
        end
      end
      StShift: begin
        {acc_d, shreg_d} = {acc_corr, shreg_q} << 1;
        cnt_d            = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = StDone;
      end
      StDone: begin
        digits_d    = acc_q;
`ifndef ERROR_STICKY_EN
        error_d     = 4'd0;
`endif
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end
      StOvf: begin
        error_d     = ERR_OVF;
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      digits_q    <= '0;
      error_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      error_q     <= error_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= (state_d == StIdle);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign num0      = digits_q[15:12];
  assign num1      = digits_q[11:8];
  assign num2      = digits_q[7:4];
  assign num3      = digits_q[3:0];
  assign error     = error_q;

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Bench for bin_to_bcd_digits: directed cases plus random values against a decimal-arithmetic model.
module tb_bin_to_bcd_digits;

  localparam int unsigned WIDTH = 14;
  localparam int unsigned MAXV  = 9999;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] bin_in;
  logic             err_clr;
  logic             out_valid;
  logic [3:0]       num0, num1, num2, num3, error;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_digits;
  logic [3:0]  exp_err;
  time         t_prev;
`ifdef ERROR_STICKY_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  bin_to_bcd_digits dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .err_clr   (err_clr),
    .out_valid (out_valid),
    .num0      (num0),
    .num1      (num1),
    .num2      (num2),
    .num3      (num3),
    .error     (error)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Send one value, wait for its result, check latency/digits/error; returns at the result cycle.
  task automatic send(input int v, input bit chain);
    int lat;
    int waitc;
    bit seen;
    bit ovf;
    ovf   = (v > int'(MAXV));
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_before_send", 32'(in_ready), 32'd1);
    bin_in   = WIDTH'(v);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    bin_in   = WIDTH'($urandom);
    check("busy_after_transfer", 32'(in_ready), 32'd0);
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) lat = 99;
    if (ovf) exp_err = 4'd1;
    else begin
      exp_digits = to_bcd(v);
      if (!Sticky) exp_err = 4'd0;
    end
    check("latency", 32'(lat), ovf ? 32'd1 : 32'(WIDTH + 1));
    check("digits", 32'({num0, num1, num2, num3}), 32'(exp_digits));
    check("error", 32'(error), 32'(exp_err));
    check("ready_at_result", 32'(in_ready), 32'd1);
    t_prev = $time;
    if (!chain) begin
      @(negedge clk);
      check("pulse_single", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    if (Sticky) exp_err = 4'd0;
    check("err_clr", 32'(error), 32'(exp_err));
  endtask

  initial begin
    time t_first;
    int  ov_cnt;
    int  v;
    rst        = 1'b1;
    in_valid   = 1'b0;
    err_clr    = 1'b0;
    bin_in     = '0;
    exp_digits = 16'h0000;
    exp_err    = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_digits", 32'({num0, num1, num2, num3}), 32'h0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);

    send(1234, 1'b0);

    // Back-to-back: second value offered the cycle in_ready returns.
    send(9999, 1'b1);
    t_first = t_prev;
    send(0, 1'b0);
    check("b2b_spacing", 32'((t_prev - t_first) / 10), 32'(WIDTH + 2));

    send(4321, 1'b0);
    send(10000, 1'b0);
    pulse_clr();

    send(16383, 1'b0);
    send(MAXV + 1, 1'b0);
    send(42, 1'b0);
    pulse_clr();
    send(MAXV, 1'b0);

    // Abort a conversion with reset five cycles in.
    @(negedge clk);
    bin_in   = WIDTH'(777);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    exp_digits = 16'h0000;
    exp_err    = 4'd0;
    check("abort_digits", 32'({num0, num1, num2, num3}), 32'h0);
    check("abort_error", 32'(error), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    ov_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov_cnt++;
    end
    check("abort_no_valid", 32'(ov_cnt), 32'd0);

    for (int i = 0; i < 25; i++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383))
                                      : int'($urandom_range(0, 9999));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(v, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
